rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Round-robin arbiter and sample sequencer that shares the single 8-bit LFSR random source among several requesters in the neural-network datapath (e.g. weight-init and dropout-mask units). It grants one requester at a time, then strobes the LFSR `read` input four times, spaced so that every sampled byte is fully refreshed. It packs the four bytes into a 32-bit word and returns it to the granted requester with a one-cycle valid pulse.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `SAMPLE_GAP`, default 8: idle cycles between consecutive LFSR reads; minimum 1. The default of 8 makes every byte disjoint for an 8-bit shift LFSR.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request, one bit per requester.
- `gnt` out NUM_REQ: one-hot grant, held for the whole transaction.
- `rvalid` out NUM_REQ: one-hot, one-cycle pulse; `rdata` is valid during it.
- `rdata` out 32: packed random word.
- `busy` out 1: high while any transaction is in progress.
- `lfsr_read` out 1: registered read strobe to the LFSR.
- `lfsr_data` in 32: LFSR `read_data`; only [7:0] is used and [31:8] is ignored.

## Operation
- States: IDLE, READ, CAP, GAP, DONE.
- IDLE:
  - If `req` is nonzero, select the first set bit scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... (wrap).
  - Register one-hot `gnt`, clear the byte counter and accumulator, go to READ.
  - Otherwise stay in IDLE.
- READ: `lfsr_read`=1 for exactly this cycle, go to CAP.
- CAP:
  - Capture `acc <= {acc[23:0], lfsr_data[7:0]}` and increment the byte counter (0..3).
  - If this was byte 3, go to DONE; otherwise load the gap counter and go to GAP.
- GAP: stay for exactly SAMPLE_GAP cycles, then go to READ.
- DONE:
  - `rvalid[i]`=1 and `rdata`=acc for the granted index i; `gnt[i]` is still 1.
  - Set ptr <= (i+1) mod NUM_REQ, go to IDLE.
  - `gnt`, `rvalid` and `busy` are 0 from the next cycle.
- Byte order: the first captured byte lands in `rdata[31:24]`, the last in `rdata[7:0]`.
- `busy` is 1 in READ, CAP, GAP and DONE.
- `req` is sampled only in IDLE:
  - Dropping `req` mid-transaction does not abort it; the word is still delivered.
  - A requester still holding `req` after its `rvalid` is re-eligible, but after all others because of the ptr advance.
- Simultaneous requests: only the pointer order matters. Requests arriving during a transaction wait and are never lost while held.
- `rdata` holds its last value outside DONE. Bench checks sample it only when `rvalid` is 1.
- Reset (asynchronous, any state):
  - Go to IDLE; ptr=0, acc=0, counters=0.
  - `gnt`=0, `rvalid`=0, `rdata`=0, `lfsr_read`=0, `busy`=0.
  - A transaction in flight is discarded with no `rvalid`.

## Timing
- Let cycle 0 be the IDLE cycle where `req` is seen.
- Cycle 1: `gnt` and `busy` high; `lfsr_read` high (READ).
- LFSR contract: the LFSR registers `read_data` on the edge ending a `lfsr_read` cycle, so the CAP cycle that follows samples it.
- Byte k (k=0..3): READ at cycle 1+k(SAMPLE_GAP+2), CAP one cycle later.
- DONE at cycle 3+3(SAMPLE_GAP+2); with the default this is cycle 33.
- Back-to-back transactions: the next grant appears at cycle 35 at the earliest (IDLE at 34).
- `lfsr_read` pulses are one cycle wide and exactly SAMPLE_GAP+2 cycles apart within a transaction.
- `lfsr_read` never asserts in IDLE or DONE.

## Test plan
- Reset values: hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `rvalid`=0, `rdata`=0, `lfsr_read`=0, `busy`=0.
- Single request, LFSR stub returning 0x01, 0x02, 0x03, 0x04 on successive reads, `req`=4'b0100 asserted at cycle 0:
  - `gnt`=4'b0100 at cycles 1..33.
  - `lfsr_read` pulses at cycles 1, 11, 21, 31.
  - `rvalid`=4'b0100 with `rdata`=0x01020304 at cycle 33; everything idle at cycle 34.
- Fairness: `req`=4'b1111 held after reset → grant order 0, 1, 2, 3, 0. Each `gnt` lasts 33 cycles with a 1-cycle gap between grants.
- Drop `req` mid-transaction: `req[1]` deasserted at cycle 5 → transaction completes and `rvalid[1]` pulses at cycle 33 with the full word.
- Reset mid-operation: `rst_n` low at cycle 15 of a transaction → all outputs 0 immediately, no `rvalid`. After release, a `req` on port 2 is granted at the next IDLE cycle+1 (ptr back to 0).
- SAMPLE_GAP=1 build:
  - Reads at cycles 1, 4, 7, 10; DONE at cycle 12.
  - With the real LFSR after reset, the captured bytes match the bench LFSR model.
  - `lfsr_data[31:8]` driven to 0xFFFFFF has no effect on `rdata`.

Source files
------------

// File: rtl/rng_arbiter_if.sv
// rtl/rng_arbiter_if.sv - Requester and LFSR signal bundle for rng_arbiter
//
// Ports (signals in the bundle):
//   req       requester -> arbiter : level request, one bit per requester
//   gnt       arbiter -> requester : one-hot grant, held for the transaction
//   rvalid    arbiter -> requester : one-hot, one-cycle data-valid pulse
//   rdata     arbiter -> requester : packed 32-bit random word
//   busy      arbiter -> requester : transaction in progress
//   lfsr_read arbiter -> LFSR      : registered read strobe
//   lfsr_data LFSR -> arbiter      : LFSR read data, only [7:0] is used
// The slave modport is the arbiter's view; master is the surrounding datapath.

interface rng_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid;
    logic [31:0]        rdata;
    logic               busy;
    logic               lfsr_read;
    logic [31:0]        lfsr_data;

    modport master (
        output req,
        output lfsr_data,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  busy,
        input  lfsr_read
    );

    modport slave (
        input  req,
        input  lfsr_data,
        output gnt,
        output rvalid,
        output rdata,
        output busy,
        output lfsr_read
    );
endinterface

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - Round-robin arbiter and 4-byte sequencer for a shared 8-bit LFSR
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rng_arbiter_if.slave (req/gnt/rvalid/rdata/busy/lfsr_read/lfsr_data)
// Parameters:
//   NUM_REQ    : number of requesters (2..16)
//   SAMPLE_GAP : idle cycles between consecutive LFSR reads (>= 1)

module rng_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SAMPLE_GAP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rng_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAP,
        GAP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]        acc_q, acc_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               lfsr_read_q, lfsr_read_d;

    // The LFSR is 8 bits wide; the upper read_data bits carry nothing useful.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^bus.lfsr_data[31:8];

    // Round-robin pick: first set req bit scanning ptr, ptr+1, ... with wrap.
    logic             found;
    logic [PTR_W-1:0] pick;
    logic [PTR_W:0]   cand;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && bus.req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[PTR_W-1:0];
            end
        end
    end

    // Outputs are registered: each *_d reflects what the next state drives.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        acc_d       = acc_q;
        gnt_d       = gnt_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        rvalid_d    = '0;
        lfsr_read_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d       = pick;
                    gnt_d       = NUM_REQ'(1) << pick;
                    byte_cnt_d  = '0;
                    acc_d       = '0;
                    busy_d      = 1'b1;
                    lfsr_read_d = 1'b1;
                    state_d     = READ;
                end
            end
            READ: begin
                state_d = CAP;
            end
            CAP: begin
                // First byte captured ends up in [31:24] after four shifts.
                acc_d      = {acc_q[23:0], bus.lfsr_data[7:0]};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    rvalid_d = gnt_q;
                    rdata_d  = acc_d;
                    state_d  = DONE;
                end else begin
                    gap_cnt_d = GAP_W'(SAMPLE_GAP - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    lfsr_read_d = 1'b1;
                    state_d     = READ;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                // Served requester drops to lowest priority.
                ptr_d   = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            acc_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            lfsr_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            acc_q       <= acc_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            lfsr_read_q <= lfsr_read_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.lfsr_read = lfsr_read_q;
endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - Self-checking bench for rng_arbiter (SAMPLE_GAP 8 and 1 builds)

module tb_rng_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rng_arbiter_if #(.NUM_REQ(4)) ifa ();
    rng_arbiter_if #(.NUM_REQ(4)) ifb ();

    rng_arbiter #(.NUM_REQ(4), .SAMPLE_GAP(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rng_arbiter #(.NUM_REQ(4), .SAMPLE_GAP(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int ptr_m[2];
    logic [7:0] stub_q[$];
    logic [7:0] lfsr_s;

    function automatic logic [7:0] lstep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Stub for build A: returns queued bytes in order, random upper bits.
    always @(posedge clk) begin
        if (!rst_n) begin
            ifa.lfsr_data <= '0;
        end else if (ifa.lfsr_read) begin
            if (stub_q.size() > 0) ifa.lfsr_data <= {24'($urandom), stub_q.pop_front()};
            else                   ifa.lfsr_data <= {24'($urandom), 8'($urandom)};
        end
    end

    // Free-running 8-bit LFSR for build B, registered on read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_s <= 8'h01;
        else        lfsr_s <= lstep(lfsr_s);
    end

    always @(posedge clk) begin
        if (!rst_n)              ifb.lfsr_data <= 32'hFFFFFFFF;
        else if (ifb.lfsr_read)  ifb.lfsr_data <= {24'hFFFFFF, lfsr_s};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle done+1.
    task automatic run_txn(input int sel, input logic [3:0] r, input bit given,
                           input logic [31:0] w_in, input int drop_at,
                           input logic [3:0] r_drop, output logic [3:0] g_obs);
        int gap, per, done, g, c;
        logic [3:0]  oh, o_gnt, o_rv;
        logic [31:0] w, o_rdata;
        logic [7:0]  s;
        logic        o_busy, o_rd, e_rd;
        gap  = (sel != 0) ? 1 : 8;
        per  = gap + 2;
        done = 3 + 3 * per;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            c = (ptr_m[sel] + k) % 4;
            if (g < 0 && r[c]) g = c;
        end
        oh = 4'b0001 << g;
        ptr_m[sel] = (g + 1) % 4;
        if (sel == 0) begin
            w = given ? w_in : 32'($urandom);
            for (int k = 0; k < 4; k++) stub_q.push_back(w[31-8*k -: 8]);
            ifa.req = r;
        end else begin
            s = lfsr_s;
            w = '0;
            for (int n = 1; n <= 10; n++) begin
                s = lstep(s);
                if (n % 3 == 1) w = {w[23:0], s};
            end
            ifb.req = r;
        end
        g_obs = '0;
        for (int t = 1; t <= done + 1; t++) begin
            @(negedge clk);
            o_gnt   = (sel != 0) ? ifb.gnt       : ifa.gnt;
            o_rv    = (sel != 0) ? ifb.rvalid    : ifa.rvalid;
            o_rdata = (sel != 0) ? ifb.rdata     : ifa.rdata;
            o_busy  = (sel != 0) ? ifb.busy      : ifa.busy;
            o_rd    = (sel != 0) ? ifb.lfsr_read : ifa.lfsr_read;
            if (t == 1) g_obs = o_gnt;
            e_rd = (t <= done - 2) && ((t - 1) % per == 0);
            chk($sformatf("gnt%0d t%0d", sel, t), 32'(o_gnt), (t <= done) ? 32'(oh) : 32'd0);
            chk($sformatf("busy%0d t%0d", sel, t), 32'(o_busy), (t <= done) ? 32'd1 : 32'd0);
            chk($sformatf("lfsr_read%0d t%0d", sel, t), 32'(o_rd), 32'(e_rd));
            chk($sformatf("rvalid%0d t%0d", sel, t), 32'(o_rv), (t == done) ? 32'(oh) : 32'd0);
            if (t == done) chk($sformatf("rdata%0d", sel), o_rdata, w);
            if (t == drop_at) begin
                if (sel != 0) ifb.req = r_drop;
                else          ifa.req = r_drop;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] go, r, rd;
        int order[5];
        int drop;
        order = '{0, 1, 2, 3, 0};
        ptr_m = '{0, 0};

        rst_n = 1'b0;
        ifa.req = 4'b1111;
        ifb.req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_gnt_a", 32'(ifa.gnt), 0);
        chk("rst_rvalid_a", 32'(ifa.rvalid), 0);
        chk("rst_rdata_a", ifa.rdata, 0);
        chk("rst_read_a", 32'(ifa.lfsr_read), 0);
        chk("rst_busy_a", 32'(ifa.busy), 0);
        chk("rst_gnt_b", 32'(ifb.gnt), 0);
        chk("rst_rvalid_b", 32'(ifb.rvalid), 0);
        chk("rst_rdata_b", ifb.rdata, 0);
        chk("rst_read_b", 32'(ifb.lfsr_read), 0);
        chk("rst_busy_b", 32'(ifb.busy), 0);
        ifa.req = '0;
        ifb.req = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness with all requests held.
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 4'b1111, 1'b0, 32'd0, 0, 4'b0000, go);
            chk($sformatf("fair_order%0d", i), 32'(go), 32'(4'b0001 << order[i]));
        end
        ifa.req = '0;
        @(negedge clk);

        // Directed single request with known bytes.
        run_txn(0, 4'b0100, 1'b1, 32'h01020304, 0, 4'b0000, go);
        chk("single_gnt", 32'(go), 32'(4'b0100));
        ifa.req = '0;

        // Request dropped at cycle 5 still completes.
        run_txn(0, 4'b0010, 1'b0, 32'd0, 5, 4'b0000, go);
        chk("drop_gnt", 32'(go), 32'(4'b0010));

        // Random requests, sometimes changed mid-transaction.
        for (int i = 0; i < 8; i++) begin
            r    = 4'($urandom_range(1, 15));
            drop = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 30)) : 0;
            rd   = 4'($urandom_range(0, 15));
            run_txn(0, r, 1'b0, 32'd0, drop, rd, go);
        end
        ifa.req = '0;
        @(negedge clk);

        // Reset mid-transaction at cycle 15.
        ifa.req = 4'b0100;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(ifa.gnt), 0);
        chk("mid_rst_rvalid", 32'(ifa.rvalid), 0);
        chk("mid_rst_rdata", ifa.rdata, 0);
        chk("mid_rst_read", 32'(ifa.lfsr_read), 0);
        chk("mid_rst_busy", 32'(ifa.busy), 0);
        stub_q.delete();
        ifa.req = '0;
        ptr_m = '{0, 0};
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_rvalid", 32'(ifa.rvalid), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(ifa.rvalid), 0);
        run_txn(0, 4'b1100, 1'b0, 32'd0, 0, 4'b0000, go);
        chk("post_rst_gnt", 32'(go), 32'(4'b0100));
        ifa.req = '0;
        @(negedge clk);

        // SAMPLE_GAP=1 build against the free-running LFSR.
        for (int i = 0; i < 4; i++) begin
            r = 4'($urandom_range(1, 15));
            run_txn(1, r, 1'b0, 32'd0, 0, 4'b0000, go);
        end
        ifb.req = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
